// File: rtl/ccr_ctrl.sv
// ============================================================================
// Module   : ccr_ctrl
// Purpose  : EX-stage ALU opcode decoder and condition-code register owner,
//            with a small LIFO shadow stack for interrupt entry / RTI.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ccr_ctrl #(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [4:0]  opcode,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  alu_flags,
  input  logic        int_take,
  input  logic        rti_ret,
  output logic [12:0] alu_sel,
  output logic        setc,
  output logic        clrc,
  output logic [2:0]  ccr,
  output logic [2:0]  ccr_next,
  output logic [2:0]  shadow_cnt,
  output logic        err_ovf,
  output logic        err_udf
);

  localparam logic [4:0] c_OP_SETC = 5'd1;
  localparam logic [4:0] c_OP_CLRC = 5'd2;
  localparam logic [4:0] c_OP_NOT  = 5'd3;
  localparam logic [4:0] c_OP_INC  = 5'd4;
  localparam logic [4:0] c_OP_DEC  = 5'd5;
  localparam logic [4:0] c_OP_MOV  = 5'd6;
  localparam logic [4:0] c_OP_ADD  = 5'd7;
  localparam logic [4:0] c_OP_SUB  = 5'd8;
  localparam logic [4:0] c_OP_AND  = 5'd9;
  localparam logic [4:0] c_OP_OR   = 5'd10;
  localparam logic [4:0] c_OP_SHL  = 5'd11;
  localparam logic [4:0] c_OP_SHR  = 5'd12;
  localparam logic [4:0] c_OP_IN   = 5'd13;
  localparam logic [4:0] c_OP_LDM  = 5'd14;

  localparam logic [2:0] c_DEPTH = 3'(SHADOW_DEPTH);

  logic [12:0]                  w_sel;
  logic                         w_zn_upd;
  logic                         w_commit;
  logic [2:0]                   w_upd;
  logic                         w_push_req;
  logic                         w_pop_req;
  logic                         w_push;
  logic                         w_pop;
  logic [2:0]                   w_top;
  logic [2:0]                   w_ccr_next;
  logic [2:0]                   r_ccr;
  logic [2:0]                   r_cnt;
  logic                         r_ovf;
  logic                         r_udf;
  logic [SHADOW_DEPTH-1:0][2:0] r_shadow;

  assign w_commit = ex_valid & ~flush & ~stall;

  always_comb begin
    w_sel    = '0;
    w_zn_upd = 1'b0;
    case (opcode)
      c_OP_SETC, c_OP_CLRC: w_sel[12] = 1'b1;
      c_OP_ADD: begin w_sel[0] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_NOT: begin w_sel[1] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_INC: begin w_sel[2] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_DEC: begin w_sel[3] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_SUB: begin w_sel[4] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_AND: begin w_sel[5] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_OR:  begin w_sel[6] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_SHL: begin w_sel[7] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_SHR: begin w_sel[8] = 1'b1; w_zn_upd = 1'b1; end
      c_OP_MOV: w_sel[9]  = 1'b1;
      c_OP_IN:  w_sel[10] = 1'b1;
      c_OP_LDM: w_sel[11] = 1'b1;
      default: ;
    endcase
  end

  assign alu_sel = w_commit ? w_sel : 13'd0;
  assign setc    = w_commit & (opcode == c_OP_SETC);
  assign clrc    = w_commit & (opcode == c_OP_CLRC);

  // Flag update from the EX instruction alone, before any RTI override.
  always_comb begin
    w_upd = r_ccr;
    if (w_commit) begin
      if (w_zn_upd)                 w_upd[1:0] = alu_flags[1:0];
      if (opcode == c_OP_ADD)       w_upd[2]   = alu_flags[2];
      else if (opcode == c_OP_SETC) w_upd[2]   = 1'b1;
      else if (opcode == c_OP_CLRC) w_upd[2]   = 1'b0;
    end
  end

  assign w_push_req = ~stall & int_take;
  assign w_pop_req  = ~stall & rti_ret & ~int_take;
  assign w_push     = w_push_req & (r_cnt < c_DEPTH);
  assign w_pop      = w_pop_req & (r_cnt != 3'd0);

  always_comb begin
    w_top = '0;
    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (r_cnt == 3'(i + 1)) w_top = r_shadow[i];
    end
  end

  assign w_ccr_next = w_pop ? w_top : w_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ccr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ccr <= w_ccr_next;
      if (w_push)     r_cnt <= r_cnt + 3'd1;
      else if (w_pop) r_cnt <= r_cnt - 3'd1;
      if (w_push_req && !w_push) r_ovf <= 1'b1;
      if (w_pop_req && !w_pop)   r_udf <= 1'b1;
    end
  end

  // Entry i is written when it is the next free slot; the pushed value is
  // the post-update CCR so an interrupt sees the interrupted op's flags.
  for (genvar i = 0; i < SHADOW_DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow[i] <= '0;
      end else if (w_push && (r_cnt == 3'(i))) begin
        r_shadow[i] <= w_ccr_next;
      end
    end
  end

  assign ccr        = r_ccr;
  assign ccr_next   = w_ccr_next;
  assign shadow_cnt = r_cnt;
  assign err_ovf    = r_ovf;
  assign err_udf    = r_udf;

endmodule

`default_nettype wire
